// File: rtl/obi_dbus_arbiter.sv
// Four-way OBI data-port arbiter (load/store/AMO/PTW). Zero added latency, in-order response routing.
// Optional stall/perf counters under `CVA6_OBI_ARB_PERF_EN; grants gated by a full FIFO or a pending AMO.
module obi_dbus_arbiter #(
  parameter int unsigned AddrWidth      = 34,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [3:0]                          req_i,
  input  logic [3:0][AddrWidth-1:0]           addr_i,
  input  logic [3:0]                          we_i,
  input  logic [3:0][DataWidth/8-1:0]         be_i,
  input  logic [3:0][DataWidth-1:0]           wdata_i,
  input  logic [3:0][IdWidth-1:0]             aid_i,
  output logic [3:0]                          gnt_o,
  output logic [3:0]                          rvalid_o,
  input  logic [3:0]                          rready_i,
  output logic [DataWidth-1:0]                rdata_o,
  output logic [IdWidth-1:0]                  rid_o,
  output logic                                err_o,
  output logic                                mem_req_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic                                mem_we_o,
  output logic [DataWidth/8-1:0]              mem_be_o,
  output logic [DataWidth-1:0]                mem_wdata_o,
  output logic [IdWidth-1:0]                  mem_aid_o,
  input  logic                                mem_gnt_i,
  input  logic                                mem_rvalid_i,
  output logic                                mem_rready_o,
  input  logic [DataWidth-1:0]                mem_rdata_i,
  input  logic [IdWidth-1:0]                  mem_rid_i,
  input  logic                                mem_err_i
`ifdef CVA6_OBI_ARB_PERF_EN
  ,
  output logic [3:0]                          perf_stall_o,
  output logic [3:0][15:0]                    perf_cnt_o
`endif
);

  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam logic [1:0] IdxLoad  = 2'd0;
  localparam logic [1:0] IdxStore = 2'd1;
  localparam logic [1:0] IdxAmo   = 2'd2;
  localparam logic [1:0] IdxPtw   = 2'd3;

  logic            lock_vld;
  logic [1:0]      lock_idx;
  logic [1:0]      rr_ptr;
  logic            amo_pending;
  logic [1:0]      sel_idx;
  logic [1:0]      cur_idx;
  logic [1:0]      rr_order [3];
  logic            push;
  logic            pop;
  logic [1:0]      fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW:0]   count;
  logic            fifo_empty;
  logic            fifo_full;
  logic [1:0]      head;

  // PTW always wins a fresh selection; the rest rotate starting at rr_ptr.
  always_comb begin
    case (rr_ptr)
      IdxLoad:  begin rr_order[0] = IdxLoad;  rr_order[1] = IdxStore; rr_order[2] = IdxAmo;   end
      IdxStore: begin rr_order[0] = IdxStore; rr_order[1] = IdxAmo;   rr_order[2] = IdxLoad;  end
      default:  begin rr_order[0] = IdxAmo;   rr_order[1] = IdxLoad;  rr_order[2] = IdxStore; end
    endcase
    sel_idx = IdxLoad;
    for (int k = 2; k >= 0; k--) begin
      if (req_i[rr_order[k]]) sel_idx = rr_order[k];
    end
    if (req_i[IdxPtw]) sel_idx = IdxPtw;
  end

  assign cur_idx    = lock_vld ? lock_idx : sel_idx;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PtrW+1)'(MaxOutstanding));
  assign head       = fifo_q[rd_ptr];

  assign mem_req_o   = (lock_vld | (|req_i)) & ~fifo_full & ~amo_pending;
  assign mem_addr_o  = addr_i[cur_idx];
  assign mem_we_o    = we_i[cur_idx];
  assign mem_be_o    = be_i[cur_idx];
  assign mem_wdata_o = wdata_i[cur_idx];
  assign mem_aid_o   = aid_i[cur_idx];

  assign push = mem_req_o & mem_gnt_i;
  assign pop  = mem_rvalid_i & mem_rready_o;

  always_comb begin
    gnt_o = '0;
    if (push) gnt_o[cur_idx] = 1'b1;
  end

  always_comb begin
    rvalid_o = '0;
    if (mem_rvalid_i && !fifo_empty) rvalid_o[head] = 1'b1;
  end

  assign mem_rready_o = ~fifo_empty & rready_i[head];
  assign rdata_o      = mem_rdata_i;
  assign rid_o        = mem_rid_i;
  assign err_o        = mem_err_i;

  // The selection is frozen once presented so a late PTW cannot change the address mid-handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_vld <= 1'b0;
      lock_idx <= IdxLoad;
      rr_ptr   <= IdxStore;
    end else begin
      lock_vld <= mem_req_o & ~mem_gnt_i;
      if (mem_req_o & ~mem_gnt_i) lock_idx <= cur_idx;
      if (push && cur_idx != IdxPtw) rr_ptr <= (cur_idx == IdxAmo) ? IdxLoad : cur_idx + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      amo_pending <= 1'b0;
    end else if (push && cur_idx == IdxAmo) begin
      amo_pending <= 1'b1;
    end else if (pop && head == IdxAmo) begin
      amo_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= cur_idx;
  end

`ifdef CVA6_OBI_ARB_PERF_EN
  logic [3:0][15:0] perf_cnt_q;

  assign perf_stall_o = req_i & ~gnt_o;
  assign perf_cnt_o   = perf_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (perf_stall_o[i] && perf_cnt_q[i] != 16'hFFFF) perf_cnt_q[i] <= perf_cnt_q[i] + 16'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // A requester holding a locked slot must keep requesting until granted.
  assert property (@(posedge clk_i) disable iff (rst_i) lock_vld |-> req_i[lock_idx]);
  // A response with nothing outstanding is a downstream protocol violation.
  assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && fifo_empty));
`endif

endmodule

// File: tb/tb_obi_dbus_arbiter.sv
// Directed bench for obi_dbus_arbiter: reset, routing, priority, lock, FIFO full and AMO gating.
module tb_obi_dbus_arbiter;
  localparam int AW = 34;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [3:0]              req;
  logic [3:0][AW-1:0]      addr;
  logic [3:0]              we;
  logic [3:0][DW/8-1:0]    be;
  logic [3:0][DW-1:0]      wdata;
  logic [3:0][IW-1:0]      aid;
  logic [3:0]              gnt;
  logic [3:0]              rvalid;
  logic [3:0]              rready;
  logic [DW-1:0]           rdata;
  logic [IW-1:0]           rid;
  logic                    err;
  logic                    mem_req;
  logic [AW-1:0]           mem_addr;
  logic                    mem_we;
  logic [DW/8-1:0]         mem_be;
  logic [DW-1:0]           mem_wdata;
  logic [IW-1:0]           mem_aid;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic                    mem_rready;
  logic [DW-1:0]           mem_rdata;
  logic [IW-1:0]           mem_rid;
  logic                    mem_err;

  int checks = 0;
  int failures = 0;

  obi_dbus_arbiter #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .aid_i(aid), .gnt_o(gnt), .rvalid_o(rvalid), .rready_i(rready),
    .rdata_o(rdata), .rid_o(rid), .err_o(err), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_aid_o(mem_aid),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready),
    .mem_rdata_i(mem_rdata), .mem_rid_i(mem_rid), .mem_err_i(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req = '0; we = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    rready = 4'b1111; mem_rdata = '0; mem_rid = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = AW'(34'h100 * (i + 1));
      be[i]    = 4'hF;
      wdata[i] = 32'hA0A0_0000 + i;
      aid[i]   = IW'(i);
    end
    we[1] = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (rvalid !== 4'b0000) begin failures++; $display("FAIL reset_rvalid got=%b exp=0000", rvalid); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_rready !== 1'b0) begin failures++; $display("FAIL reset_mem_rready got=%b exp=0", mem_rready); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset();
    tick(); req = 4'b0001; addr[0] = AW'(34'h100); #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL load_mem_req got=%b exp=1", mem_req); end
    checks++; if (mem_addr !== AW'(34'h100)) begin failures++; $display("FAIL load_addr got=%h exp=100", mem_addr); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL load_gnt_early got=%b exp=0000", gnt); end
    tick(); #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL load_gnt_wait got=%b exp=0000", gnt); end
    tick(); mem_gnt = 1'b1; #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL load_gnt got=%b exp=0001", gnt); end
    tick(); req = '0; mem_gnt = 1'b0;
    tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    checks++; if (rvalid !== 4'b0001) begin failures++; $display("FAIL load_rvalid got=%b exp=0001", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_rdata got=%h exp=deadbeef", rdata); end
    checks++; if (mem_rready !== 1'b1) begin failures++; $display("FAIL load_mem_rready got=%b exp=1", mem_rready); end
    tick(); mem_rvalid = 1'b0;
  endtask

  task automatic test_priority_order();
    do_reset();
    tick(); req = 4'b1011; mem_gnt = 1'b1; #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL prio_first got=%b exp=1000", gnt); end
    checks++; if (mem_aid !== 2'd3) begin failures++; $display("FAIL prio_aid got=%0d exp=3", mem_aid); end
    tick(); req = 4'b0011; #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL prio_second got=%b exp=0010", gnt); end
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL prio_store_we got=%b exp=1", mem_we); end
    tick(); req = 4'b0001; #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL prio_third got=%b exp=0001", gnt); end
    tick(); req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rid = 2'd3; #1;
    checks++; if (rvalid !== 4'b1000) begin failures++; $display("FAIL resp_first got=%b exp=1000", rvalid); end
    checks++; if (rid !== 2'd3) begin failures++; $display("FAIL resp_rid got=%0d exp=3", rid); end
    tick(); mem_rid = 2'd1; #1;
    checks++; if (rvalid !== 4'b0010) begin failures++; $display("FAIL resp_second got=%b exp=0010", rvalid); end
    tick(); mem_rid = 2'd0; #1;
    checks++; if (rvalid !== 4'b0001) begin failures++; $display("FAIL resp_third got=%b exp=0001", rvalid); end
    tick(); mem_rvalid = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    tick(); req = 4'b0001; #1;
    checks++; if (mem_addr !== addr[0]) begin failures++; $display("FAIL lock_addr0 got=%h exp=%h", mem_addr, addr[0]); end
    tick(); req = 4'b1001; #1;
    checks++; if (mem_addr !== AW'(34'h100)) begin failures++; $display("FAIL lock_held_addr got=%h exp=100", mem_addr); end
    tick(); mem_gnt = 1'b1; #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_load_gnt got=%b exp=0001", gnt); end
    tick(); req = 4'b1000; #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL lock_ptw_gnt got=%b exp=1000", gnt); end
    tick(); req = '0; mem_gnt = 1'b0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); req = 4'b0001; mem_gnt = 1'b1; #1;
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL full_fill%0d got=%b exp=0001", i, gnt); end
    end
    tick(); req = 4'b0010; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_gate got=%b exp=0", mem_req); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL full_no_gnt got=%b exp=0000", gnt); end
    tick(); mem_rvalid = 1'b1; #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL full_pop_cycle got=%b exp=0", mem_req); end
    checks++; if (rvalid !== 4'b0001) begin failures++; $display("FAIL full_rvalid got=%b exp=0001", rvalid); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL full_store_gnt got=%b exp=0010", gnt); end
    tick(); req = '0; mem_gnt = 1'b0;
  endtask

  task automatic test_amo();
    do_reset();
    tick(); req = 4'b0100; mem_gnt = 1'b1; #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL amo_gnt got=%b exp=0100", gnt); end
    for (int i = 0; i < 2; i++) begin
      tick(); req = 4'b0001; #1;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL amo_block%0d got=%b exp=0", i, mem_req); end
    end
    tick(); mem_rvalid = 1'b1; #1;
    checks++; if (rvalid !== 4'b0100) begin failures++; $display("FAIL amo_rvalid got=%b exp=0100", rvalid); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL amo_resp_cycle_gnt got=%b exp=0000", gnt); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL amo_load_after got=%b exp=0001", gnt); end
    tick(); req = '0; mem_gnt = 1'b0;
  endtask

  task automatic test_rr_three();
    do_reset();
    tick(); req = 4'b0111; mem_gnt = 1'b1; #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rr_store_first got=%b exp=0010", gnt); end
    tick(); req = 4'b0101; #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rr_amo_next got=%b exp=0100", gnt); end
    tick(); req = '0; mem_gnt = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(); req = 4'b0001; mem_gnt = 1'b1;
    tick(); req = '0; mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); mem_rvalid = 1'b1; rready = 4'b1110; #1;
      checks++; if (mem_rready !== 1'b0) begin failures++; $display("FAIL bp_rready%0d got=%b exp=0", i, mem_rready); end
      checks++; if (rvalid !== 4'b0001) begin failures++; $display("FAIL bp_rvalid%0d got=%b exp=0001", i, rvalid); end
    end
    tick(); rready = 4'b1111; #1;
    checks++; if (mem_rready !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", mem_rready); end
    tick(); mem_rvalid = 1'b0; #1;
    checks++; if (mem_rready !== 1'b0) begin failures++; $display("FAIL bp_empty_rready got=%b exp=0", mem_rready); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single_load();
    test_priority_order();
    test_lock();
    test_fifo_full();
    test_amo();
    test_rr_three();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
